vc_input_buffer: RTL and testbench

Parametrised router input unit: it takes the 35-bit forward flit stream of one router input port and demultiplexes it into `NUM_VC` independent virtual-channel FIFOs. It tracks packet framing per VC, exposes each VC's head flit to the switch allocator, and returns one credit per dequeued flit to the upstream router. It sits between an input link (`inPort_f`) and the crossbar-select / switch-allocation logic. It supersedes the single-queue input stage.

---
 rtl/vc_input_buffer_pkg.sv | 19 +
 rtl/vc_input_buffer_fifo.sv | 50 +++++
 rtl/vc_input_buffer.sv | 129 ++++++++++++
 tb/tb_vc_input_buffer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_input_buffer_pkg.sv
// Shared router definitions: flit bit offsets, VC framing states, defaults.
// No ports; imported by the input-buffer files.
package interact;

    localparam int LINK_WIDTH_DEF = 35;
    localparam int NUM_VC_DEF     = 2;
    localparam int VC_DEPTH_DEF   = 4;

    // Offsets below the flit MSB: bit index is LINK_WIDTH - offset.
    localparam int FLIT_VALID = 1;
    localparam int FLIT_HEAD  = 2;
    localparam int FLIT_TAIL  = 3;

    typedef enum logic {
        VC_IDLE,
        VC_PKT
    } vc_state_t;

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// vc_fifo: single-VC circular flit buffer with head output and count.
// Ports: clk, reset, push/wdata, pop, rdata (0 when empty), full, empty, count.
module vc_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/vc_input_buffer.sv
// Router input unit: demuxes one flit link into NUM_VC framed VC FIFOs.
// Ports: clk, reset, in_flit/in_vc (write), deq (pop), out_flit/out_valid
// (per-VC heads), occupancy, credit_out, sticky overflow_err/proto_err.
module vc_input_buffer
    import interact::*;
#(
    parameter int LINK_WIDTH = LINK_WIDTH_DEF,
    parameter int NUM_VC     = NUM_VC_DEF,
    parameter int DEPTH      = VC_DEPTH_DEF,
    parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [LINK_WIDTH-1:0]                 in_flit,
    input  logic [VC_W-1:0]                       in_vc,
    output logic [NUM_VC-1:0]                     credit_out,
    output logic [NUM_VC*LINK_WIDTH-1:0]          out_flit,
    output logic [NUM_VC-1:0]                     out_valid,
    input  logic [NUM_VC-1:0]                     deq,
    output logic [NUM_VC*($clog2(DEPTH)+1)-1:0]   occupancy,
    output logic                                  overflow_err,
    output logic                                  proto_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_head;
    logic                  in_tail;
    logic [NUM_VC-1:0]     push;
    logic [NUM_VC-1:0]     pop_sel;
    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     empty;
    logic [LINK_WIDTH-1:0] head [NUM_VC];
    logic [CW-1:0]         count [NUM_VC];
    vc_state_t             state_q [NUM_VC];
    vc_state_t             state_d [NUM_VC];
    logic                  seen;
    logic                  legal;
    logic                  proto_hit;
    logic                  ovf_hit;

    assign in_valid = in_flit[LINK_WIDTH-FLIT_VALID];
    assign in_head  = in_flit[LINK_WIDTH-FLIT_HEAD];
    assign in_tail  = in_flit[LINK_WIDTH-FLIT_TAIL];

    always_comb begin
        pop_sel   = '0;
        push      = '0;
        seen      = 1'b0;
        legal     = 1'b0;
        proto_hit = 1'b0;
        ovf_hit   = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v] = state_q[v];
        end

        // Lowest requested VC wins; if that VC is empty nobody pops.
        for (int v = 0; v < NUM_VC; v++) begin
            if (deq[v] && !seen) begin
                seen       = 1'b1;
                pop_sel[v] = !empty[v];
            end
        end

        if (in_valid) begin
            if (32'(in_vc) >= NUM_VC) begin
                proto_hit = 1'b1;
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (32'(in_vc) == v) begin
                    case (state_q[v])
                        VC_IDLE: legal = in_head;
                        VC_PKT:  legal = !in_head;
                        default: legal = 1'b0;
                    endcase
                    if (!legal) begin
                        proto_hit = 1'b1;
                    end else if (full[v] && !pop_sel[v]) begin
                        ovf_hit = 1'b1;
                    end else begin
                        push[v]    = 1'b1;
                        state_d[v] = in_tail ? VC_IDLE : VC_PKT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= VC_IDLE;
            end
            credit_out   <= '0;
            overflow_err <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= state_d[v];
            end
            credit_out <= pop_sel;
            if (ovf_hit)   overflow_err <= 1'b1;
            if (proto_hit) proto_err    <= 1'b1;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo #(
            .WIDTH (LINK_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[v]),
            .pop   (pop_sel[v]),
            .wdata (in_flit),
            .rdata (head[v]),
            .full  (full[v]),
            .empty (empty[v]),
            .count (count[v])
        );

        assign out_flit[v*LINK_WIDTH +: LINK_WIDTH] = head[v];
        assign occupancy[v*CW +: CW]                = count[v];
        assign out_valid[v]                         = !empty[v];
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer with a queue-based reference model.
// No ports.
module tb_vc_input_buffer;

    localparam int LW    = 35;
    localparam int NV    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int VW    = 1;
    localparam int BW    = NV + NV*LW + NV*CW + NV + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [LW-1:0]     in_flit;
    logic [VW-1:0]     in_vc;
    logic [NV-1:0]     credit_out;
    logic [NV*LW-1:0]  out_flit;
    logic [NV-1:0]     out_valid;
    logic [NV-1:0]     deq;
    logic [NV*CW-1:0]  occupancy;
    logic              overflow_err;
    logic              proto_err;
    logic [BW-1:0]     obs;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] mq [NV][$];
    bit            mpkt [NV];
    logic [NV-1:0] mcred;
    bit            movf;
    bit            mperr;

    always #5 clk = ~clk;

    vc_input_buffer #(
        .LINK_WIDTH (LW),
        .NUM_VC     (NV),
        .DEPTH      (DEPTH),
        .VC_W       (VW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_flit      (in_flit),
        .in_vc        (in_vc),
        .credit_out   (credit_out),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .deq          (deq),
        .occupancy    (occupancy),
        .overflow_err (overflow_err),
        .proto_err    (proto_err)
    );

    assign obs = {out_valid, out_flit, occupancy, credit_out,
                  overflow_err, proto_err};

    function automatic logic [LW-1:0] mk(bit h, bit t, logic [31:0] p);
        return {1'b1, h, t, p};
    endfunction

    // Reference: per-VC queues plus an "inside a packet" bit per VC.
    task automatic model_step();
        int sz [NV];
        int sel;
        int popv;
        int vv;
        bit h;
        bit t;
        bit ok;
        mcred = '0;
        if (reset) begin
            for (int v = 0; v < NV; v++) begin
                mq[v].delete();
                mpkt[v] = 0;
            end
            movf  = 0;
            mperr = 0;
            return;
        end
        for (int v = 0; v < NV; v++) sz[v] = mq[v].size();
        sel  = -1;
        popv = -1;
        for (int v = 0; v < NV; v++)
            if (deq[v] && sel < 0) sel = v;
        if (sel >= 0 && sz[sel] > 0) begin
            void'(mq[sel].pop_front());
            mcred[sel] = 1'b1;
            popv = sel;
        end
        if (in_flit[LW-1]) begin
            vv = int'(in_vc);
            if (vv >= NV) begin
                mperr = 1;
            end else begin
                h  = in_flit[LW-2];
                t  = in_flit[LW-3];
                ok = mpkt[vv] ? !h : h;
                if (!ok) mperr = 1;
                else if (sz[vv] == DEPTH && popv != vv) movf = 1;
                else begin
                    mq[vv].push_back(in_flit);
                    mpkt[vv] = !t;
                end
            end
        end
    endtask

    function automatic logic [BW-1:0] exp_bundle();
        logic [NV-1:0]    ev;
        logic [NV*LW-1:0] ef;
        logic [NV*CW-1:0] eo;
        ev = '0;
        ef = '0;
        eo = '0;
        for (int v = 0; v < NV; v++) begin
            if (mq[v].size() > 0) begin
                ev[v] = 1'b1;
                ef[v*LW +: LW] = mq[v][0];
            end
            eo[v*CW +: CW] = CW'(mq[v].size());
        end
        return {ev, ef, eo, mcred, movf, mperr};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        reset   = 1'b0;
        in_flit = '0;
        in_vc   = '0;
        deq     = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        in_flit = mk(1, 1, 32'hdead);
        in_vc   = 1'b0;
        deq     = 2'b11;
        tick();
        idle_in();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h exp 0", obs);
        end
        tick();
        checks++;
        if (obs !== exp_bundle()) begin
            errors++;
            $display("FAIL reset_idle: got %h exp %h", obs, exp_bundle());
        end
    endtask

    task automatic test_single_flit();
        logic [LW-1:0] f;
        do_reset();
        f       = mk(1, 1, 32'h0);
        in_flit = f;
        in_vc   = 1'b1;
        tick();
        idle_in();
        checks++;
        if (out_valid !== 2'b10 || out_flit[LW +: LW] !== f) begin
            errors++;
            $display("FAIL single_write: got v=%b f=%h exp v=10 f=%h",
                     out_valid, out_flit[LW +: LW], f);
        end
        deq = 2'b10;
        tick();
        idle_in();
        checks++;
        if (credit_out !== 2'b10 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_pop: got c=%b v=%b exp c=10 v=00",
                     credit_out, out_valid);
        end
        tick();
        checks++;
        if (credit_out !== 2'b00) begin
            errors++;
            $display("FAIL single_credit_pulse: got %b exp 00", credit_out);
        end
    endtask

    task automatic test_fill();
        do_reset();
        in_vc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_flit = mk(i == 0, 0, 32'h100 + i);
            tick();
        end
        idle_in();
        checks++;
        if (occupancy[CW-1:0] !== 3'd4 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL fill_four: got occ=%0d ovf=%b exp occ=4 ovf=0",
                     occupancy[CW-1:0], overflow_err);
        end
        in_flit = mk(0, 0, 32'h105);
        tick();
        idle_in();
        checks++;
        if (occupancy[CW-1:0] !== 3'd4 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: got occ=%0d ovf=%b exp occ=4 ovf=1",
                     occupancy[CW-1:0], overflow_err);
        end
        in_flit = mk(0, 1, 32'h105);
        deq     = 2'b01;
        tick();
        idle_in();
        checks++;
        if (occupancy[CW-1:0] !== 3'd4 || credit_out !== 2'b01) begin
            errors++;
            $display("FAIL fill_push_pop: got occ=%0d c=%b exp occ=4 c=01",
                     occupancy[CW-1:0], credit_out);
        end
        checks++;
        if (obs !== exp_bundle()) begin
            errors++;
            $display("FAIL fill_model: got %h exp %h", obs, exp_bundle());
        end
    endtask

    task automatic test_framing();
        do_reset();
        in_vc   = 1'b0;
        in_flit = mk(0, 0, 32'h200);
        tick();
        idle_in();
        checks++;
        if (proto_err !== 1'b1 || occupancy[CW-1:0] !== 3'd0) begin
            errors++;
            $display("FAIL frame_body_idle: got p=%b occ=%0d exp p=1 occ=0",
                     proto_err, occupancy[CW-1:0]);
        end
        do_reset();
        in_flit = mk(1, 0, 32'h201);
        tick();
        in_flit = mk(1, 0, 32'h202);
        tick();
        idle_in();
        checks++;
        if (proto_err !== 1'b1 || occupancy[CW-1:0] !== 3'd1) begin
            errors++;
            $display("FAIL frame_head_pkt: got p=%b occ=%0d exp p=1 occ=1",
                     proto_err, occupancy[CW-1:0]);
        end
        in_flit = mk(0, 1, 32'h203);
        tick();
        idle_in();
        checks++;
        if (occupancy[CW-1:0] !== 3'd2 || obs !== exp_bundle()) begin
            errors++;
            $display("FAIL frame_still_pkt: got %h exp %h", obs, exp_bundle());
        end
    endtask

    task automatic test_interleave();
        logic [LW-1:0] sent [NV][$];
        logic [LW-1:0] got  [NV][$];
        int            cred [NV];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < NV; v++) begin
                in_vc   = VW'(v);
                in_flit = mk(i == 0, i == 2, $urandom);
                sent[v].push_back(in_flit);
                tick();
            end
        end
        idle_in();
        cred[0] = 0;
        cred[1] = 0;
        for (int i = 0; i < 7; i++) begin
            deq = (i % 2 == 0) ? 2'b01 : 2'b10;
            for (int v = 0; v < NV; v++)
                if (deq[v] && out_valid[v])
                    got[v].push_back(out_flit[v*LW +: LW]);
            tick();
            for (int v = 0; v < NV; v++)
                if (credit_out[v]) cred[v]++;
        end
        idle_in();
        for (int v = 0; v < NV; v++) begin
            checks++;
            if (got[v] != sent[v] || cred[v] != 3) begin
                errors++;
                $display("FAIL interleave_vc%0d: got n=%0d cred=%0d exp n=3 cred=3",
                         v, got[v].size(), cred[v]);
            end
        end
    endtask

    task automatic test_multihot();
        do_reset();
        in_flit = mk(1, 1, 32'h300);
        in_vc   = 1'b0;
        tick();
        in_flit = mk(1, 1, 32'h301);
        in_vc   = 1'b1;
        tick();
        idle_in();
        deq = 2'b11;
        tick();
        idle_in();
        checks++;
        if (credit_out !== 2'b01 || occupancy !== {3'd1, 3'd0}) begin
            errors++;
            $display("FAIL multihot_deq: got c=%b occ=%h exp c=01 occ=08",
                     credit_out, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_vc   = 1'b0;
        in_flit = mk(1, 0, 32'h400);
        tick();
        in_flit = mk(0, 0, 32'h401);
        tick();
        reset   = 1'b1;
        in_flit = mk(0, 0, 32'h402);
        deq     = 2'b01;
        tick();
        idle_in();
        checks++;
        if (occupancy !== '0 || out_valid !== '0 || credit_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: got occ=%h v=%b c=%b exp 0",
                     occupancy, out_valid, credit_out);
        end
        in_flit = mk(1, 0, 32'h403);
        tick();
        idle_in();
        checks++;
        if (occupancy[CW-1:0] !== 3'd1 || credit_out !== '0
            || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_new_head: got occ=%0d c=%b p=%b exp 1 00 0",
                     occupancy[CW-1:0], credit_out, proto_err);
        end
    endtask

    task automatic test_random();
        int  v;
        bit  h;
        bit  t;
        int  bad = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            v     = $urandom_range(0, NV-1);
            h     = mpkt[v] ? ($urandom_range(0, 15) == 0)
                            : ($urandom_range(0, 15) != 0);
            t     = ($urandom_range(0, 2) == 0);
            in_vc = VW'(v);
            in_flit = mk(h, t, $urandom);
            if ($urandom_range(0, 9) < 2) in_flit[LW-1] = 1'b0;
            deq = NV'($urandom_range(0, 3));
            tick();
            checks++;
            if (obs !== exp_bundle()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: got %h exp %h",
                             i, obs, exp_bundle());
                bad++;
            end
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        for (int v = 0; v < NV; v++) mpkt[v] = 0;
        mcred = '0;
        movf  = 0;
        mperr = 0;
        @(negedge clk);
        test_reset();
        test_single_flit();
        test_fill();
        test_framing();
        test_interleave();
        test_multihot();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
